// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - operand/result bundle between the execute stage and the multiply/divide unit
interface mdu_if;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;

  modport master (output start, mdu_op, A, B, input HI, LO, busy);
  modport slave  (input start, mdu_op, A, B, output HI, LO, busy);
endinterface

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset,
  mdu_if.slave   bus
);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [31:0]      r_hi, r_lo;
  logic [31:0]      r_pend_hi, r_pend_lo;
  logic             r_pend_wr;

  logic [63:0] w_prod_s, w_prod_u;
  logic        w_dsgn, w_na, w_nb;
  logic [31:0] w_ua, w_ub, w_uq, w_ur, w_q, w_r;

  assign w_prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
  assign w_prod_u = {32'b0, bus.A} * {32'b0, bus.B};

  // Signed divide runs on magnitudes so that 0x80000000 / -1 wraps instead of overflowing.
  assign w_dsgn = (bus.mdu_op == OP_DIV);
  assign w_na   = w_dsgn & bus.A[31];
  assign w_nb   = w_dsgn & bus.B[31];
  assign w_ua   = w_na ? (32'd0 - bus.A) : bus.A;
  assign w_ub   = (bus.B == 32'd0) ? 32'd1 : (w_nb ? (32'd0 - bus.B) : bus.B);
  assign w_uq   = w_ua / w_ub;
  assign w_ur   = w_ua % w_ub;
  assign w_q    = (w_na ^ w_nb) ? (32'd0 - w_uq) : w_uq;
  assign w_r    = w_na ? (32'd0 - w_ur) : w_ur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.mdu_op)
              OP_MULT, OP_MULTU: begin
                {r_pend_hi, r_pend_lo} <= (bus.mdu_op == OP_MULT) ? w_prod_s : w_prod_u;
                r_pend_wr <= 1'b1;
                r_cnt     <= MULT_N;
                r_busy    <= 1'b1;
                r_state   <= ST_RUN;
              end
              OP_DIV, OP_DIVU: begin
                r_pend_hi <= w_r;
                r_pend_lo <= w_q;
                r_pend_wr <= (bus.B != 32'd0);
                r_cnt     <= DIV_N;
                r_busy    <= 1'b1;
                r_state   <= ST_RUN;
              end
              OP_MTHI: r_hi <= bus.A;
              OP_MTLO: r_lo <= bus.A;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (r_cnt == CNT_1) begin
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_pend_wr <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
  assign bus.busy = r_busy;
endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - randomized and directed self-checking bench for mdu_unit
module tb_mdu_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  mdu_if bus();

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit saw_dead = 1'b0;

  // Behavioural model: results are computed at acceptance and become visible at an absolute edge index.
  longint      m_cyc = 0;
  longint      m_done_at = 0;
  bit          m_busy = 1'b0;
  bit          m_pv = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (bus.HI === 32'hDEADBEEF) saw_dead = 1'b1;
    if (chk_en) begin
      chk("cyc_busy", {31'b0, bus.busy}, {31'b0, m_busy});
      chk("cyc_hi", bus.HI, m_hi);
      chk("cyc_lo", bus.LO, m_lo);
    end
  end

  task automatic model_accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input longint e);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    case (op)
      3'd1, 3'd2: begin
        if (op == 3'd1) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          p = 64'(sa * sb);
        end else begin
          p = {32'b0, a} * {32'b0, b};
        end
        m_phi = p[63:32];
        m_plo = p[31:0];
        m_pv = 1'b1;
        m_busy = 1'b1;
        m_done_at = e + MC;
      end
      3'd3, 3'd4: begin
        m_pv = (b != 0);
        if (b != 0) begin
          if (op == 3'd3) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            m_plo = sq[31:0];
            m_phi = sr[31:0];
          end else begin
            m_plo = a / b;
            m_phi = a % b;
          end
        end
        m_busy = 1'b1;
        m_done_at = e + DC;
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic cyc(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint e;
    bus.start = st;
    bus.mdu_op = op;
    bus.A = a;
    bus.B = b;
    e = m_cyc + 1;
    if (reset) begin
      if (m_busy) begin
        if (e == m_done_at) begin
          if (m_pv) begin
            m_hi = m_phi;
            m_lo = m_plo;
          end
          m_busy = 1'b0;
        end
      end else if (st) begin
        model_accept(op, a, b, e);
      end
    end
    m_cyc = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  // Issues one op and lets it finish; n counts sampled cycles with busy high.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
    n = 0;
    cyc(1'b1, op, a, b);
    while (bus.busy && n < 100) begin
      n++;
      idle(1);
    end
    if (n >= 100) chk("busy_timeout", 32'(n), 32'd0);
  endtask

  int n;
  logic [31:0] ra, rb;
  logic [2:0]  rop;
  logic        rst_ok;

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.mdu_op = 3'd0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", bus.HI, 32'h0);
    chk("rst_lo", bus.LO, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    reset = 1'b1;
    chk_en = 1'b1;

    run_op(3'd1, 32'hFFFFFFFD, 32'd5, n);
    chk("mult_busy_len", 32'(n), 32'd5);
    chk("mult_hi", bus.HI, 32'hFFFFFFFF);
    chk("mult_lo", bus.LO, 32'hFFFFFFF1);

    run_op(3'd2, 32'hFFFFFFFF, 32'd2, n);
    chk("multu_hi", bus.HI, 32'h00000001);
    chk("multu_lo", bus.LO, 32'hFFFFFFFE);

    run_op(3'd3, 32'hFFFFFFF9, 32'd2, n);
    chk("div_busy_len", 32'(n), 32'd10);
    chk("div_lo", bus.LO, 32'hFFFFFFFD);
    chk("div_hi", bus.HI, 32'hFFFFFFFF);

    run_op(3'd4, 32'hFFFFFFF9, 32'd2, n);
    chk("divu_lo", bus.LO, 32'h7FFFFFFC);
    chk("divu_hi", bus.HI, 32'h00000001);

    cyc(1'b1, 3'd5, 32'h12345678, 32'h0);
    chk("mthi_hi", bus.HI, 32'h12345678);
    chk("mthi_busy", {31'b0, bus.busy}, 32'h0);
    cyc(1'b1, 3'd6, 32'h9ABCDEF0, 32'h0);
    chk("mtlo_lo", bus.LO, 32'h9ABCDEF0);
    chk("mtlo_busy", {31'b0, bus.busy}, 32'h0);

    run_op(3'd4, 32'h55, 32'h0, n);
    chk("dz_busy_len", 32'(n), 32'd10);
    chk("dz_hi", bus.HI, 32'h12345678);
    chk("dz_lo", bus.LO, 32'h9ABCDEF0);

    cyc(1'b1, 3'd0, 32'hAAAA, 32'h0);
    cyc(1'b1, 3'd7, 32'hBBBB, 32'h1);
    chk("nop_busy", {31'b0, bus.busy}, 32'h0);
    chk("nop_hi", bus.HI, 32'h12345678);

    cyc(1'b1, 3'd1, 32'd7, 32'd6);
    cyc(1'b1, 3'd5, 32'hDEADBEEF, 32'h0);
    idle(1);
    cyc(1'b1, 3'd5, 32'hDEADBEEF, 32'h0);
    idle(2);
    chk("ign_hi", bus.HI, 32'h0);
    chk("ign_lo", bus.LO, 32'd42);
    chk("ign_busy", {31'b0, bus.busy}, 32'h0);
    chk("ign_never_dead", {31'b0, saw_dead}, 32'h0);

    cyc(1'b1, 3'd3, 32'd100, 32'd7);
    idle(5);
    reset = 1'b0;
    #1;
    rst_ok = 1'b1;
    chk("arst_hi", bus.HI, 32'h0);
    chk("arst_lo", bus.LO, 32'h0);
    chk("arst_busy", {31'b0, bus.busy}, 32'h0);
    m_hi = '0;
    m_lo = '0;
    m_busy = 1'b0;
    m_pv = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(15);
    chk("arst_late_lo", bus.LO, 32'h0);
    chk("arst_late_hi", bus.HI, 32'h0);

    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, n);
    chk("ovf_lo", bus.LO, 32'h80000000);
    chk("ovf_hi", bus.HI, 32'h0);
    cyc(1'b1, 3'd1, 32'd3, 32'd3);
    chk("b2b_busy", {31'b0, bus.busy}, 32'h1);
    idle(MC);
    chk("b2b_lo", bus.LO, 32'd9);
    chk("b2b_hi", bus.HI, 32'h0);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 4))
        0: ra = 32'h80000000;
        1: ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: rb = $urandom_range(1, 9);
        default: rb = $urandom;
      endcase
      rop = 3'($urandom_range(0, 7));
      cyc($urandom_range(0, 3) != 0, rop, ra, rb);
    end
    idle(DC + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
